transmitter: RTL and testbench
==============================

# transmitter

Output stage of a PGNoC router node, the opposite end of the link from `receiver`. It pops flits from the node's local FIFO and computes the XY-routed output port. It then presents each flit on exactly one of PORTS_NUM+1 output ports and holds it under a four-phase valid/ready handshake with the downstream `receiver`. Flits whose valid bit is clear are dropped silently.

## Interface
Parameters:
- DATA_SIZE, 4, payload width in bits.
- ADDR_SIZE, 2, destination address width; must be even. Upper half is X, lower half is Y.
- PORTS_NUM, 4, number of link ports; must be 4. Ports 0 N, 1 E, 2 S, 3 W; port PORTS_NUM is local.
- X_COORD, 0, this node's X coordinate.
- Y_COORD, 0, this node's Y coordinate.

Flit layout, FLIT_W = DATA_SIZE+ADDR_SIZE+1: {valid, dst_x, dst_y, payload}, with valid at the MSB.

Ports:
- clk  in  1  clock, rising edge.
- a_rst  in  1  reset, asynchronous, active-low.
- is_empty  in  1  local FIFO empty.
- data_i  in  FLIT_W  FIFO head; first-word-fall-through, valid whenever is_empty=0.
- rd_req  out  1  FIFO pop; single-cycle pulse.
- r_ready_in  in  PORTS_NUM+1  per-port acknowledge from downstream receivers.
- wr_ready_out  out  PORTS_NUM+1  per-port flit-valid; one-hot or zero.
- data_o  out  FLIT_W*(PORTS_NUM+1)  concatenated per-port flits; port p occupies slice p.

## Operation
- All outputs are registered. Reset values: rd_req=0, wr_ready_out=0, data_o=0, state=IDLE, hold register=0.
- **IDLE**
  - is_empty=1: stay in IDLE.
  - is_empty=0 and data_i valid=1: latch data_i into the hold register, latch route port p, pulse rd_req, go to SEND.
  - is_empty=0 and valid=0: pulse rd_req only (drop the flit), stay in IDLE.
- **SEND**
  - Drive wr_ready_out[p]=1 and data_o slice p = held flit. All other slices and bits are 0.
  - On an edge where r_ready_in[p]=1: clear wr_ready_out and data_o, go to RELEASE.
- **RELEASE**
  - Wait for r_ready_in[p]=0.
  - On that edge, if is_empty=0, go directly to SEND with the next head flit; the latch/pop rules are identical to IDLE.
  - Otherwise go to IDLE.
- r_ready_in bits on non-selected ports are ignored in every state.
- Routing, using dx = dst_x, dy = dst_y (unsigned compare):
  - dx>X_COORD → port 1; dx<X_COORD → port 3.
  - Otherwise dy>Y_COORD → port 2; dy<Y_COORD → port 0.
  - Otherwise local port PORTS_NUM.
- Reset asserted mid-operation returns all state and outputs to reset values asynchronously. A flit already popped but not yet acknowledged is lost. This is accepted behaviour.

## Timing
- is_empty falling (sampled at edge N) → rd_req=1 and wr_ready_out[p]=1 in cycle N+1.
- rd_req is high for exactly one cycle per popped flit. The FIFO pops on the following edge.
- Acknowledge sampled at edge M → wr_ready_out=0 in cycle M+1.
- Acknowledge low sampled at edge K → next flit presented in cycle K+1.
- Peak throughput is one flit per 2 cycles, given a same-cycle acknowledge and release.
- data_o slice p is stable for the whole SEND interval. wr_ready_out never has more than one bit set.
- r_ready_in held high indefinitely keeps the block in RELEASE with no new send (deadlock is the neighbour's fault). No timeout.

## Structure
- Package `noc_pkg` holds:
  - FLIT_W function and field offsets (VALID_BIT, ADDR_LSB).
  - Port index constants PORT_N/E/S/W/LOCAL.
  - The transmitter state enum {IDLE, SEND, RELEASE}.
- One combinational sub-module, `xy_route`: inputs dst address plus X_COORD/Y_COORD parameters, output port index. It is shared with future router logic.

## Test plan
Node (0,0), defaults, FLIT_W=7.
- Reset: a_rst=0 → all outputs 0. Release reset with is_empty=1 → outputs remain 0 for 5 cycles.
- East route: head 1_1_0_1010, is_empty 1→0 → next cycle rd_req=1, wr_ready_out=5'b00010, data_o[13:7]=7'b1101010. r_ready_in[1]=1 one cycle later → wr_ready_out=0 next cycle.
- Local route: head 1_0_0_0101 → wr_ready_out=5'b10000, data_o[34:28]=7'b1000101. Pulses on r_ready_in[0..3] are ignored; the block stays in SEND.
- Invalid drop: head 0_1_1_1111 → one rd_req pulse, wr_ready_out stays 0, state stays IDLE.
- Back-to-back: two flits, south (1_0_1_0011) then east. r_ready_in[2] held high for 3 cycles → the second flit appears on port 1 only in the cycle after r_ready_in[2] falls. Total 2 rd_req pulses.
- Mid-send reset: in SEND, assert a_rst → wr_ready_out=0 immediately. After release, a non-empty FIFO is re-read with a fresh rd_req.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared PGNoC definitions: flit geometry, port indices and transmitter states.
package noc_pkg;

   localparam int PORT_IDX_W = 3;

   localparam int PORT_N     = 0;
   localparam int PORT_E     = 1;
   localparam int PORT_S     = 2;
   localparam int PORT_W     = 3;
   localparam int PORT_LOCAL = 4;

   // Flit is {valid, dst_x, dst_y, payload}, valid at the MSB.
   function automatic int flit_w(input int data_size, input int addr_size);
      return data_size + addr_size + 1;
   endfunction

   function automatic int valid_bit(input int data_size, input int addr_size);
      return data_size + addr_size;
   endfunction

   function automatic int addr_lsb(input int data_size);
      return data_size;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      RELEASE
   } tx_state_e;

endpackage

// File: rtl/xy_route.sv
// Dimension-ordered XY route: resolve X first, then Y, else deliver locally.
module xy_route
   import noc_pkg::*;
#(
   parameter int ADDR_SIZE = 2,
   parameter int X_COORD   = 0,
   parameter int Y_COORD   = 0
) (
   input  logic [ADDR_SIZE-1:0]  dst,
   output logic [PORT_IDX_W-1:0] port
);

   localparam int HW = ADDR_SIZE / 2;

   // Widened to int so comparisons stay unsigned-by-value against any coordinate.
   int dx;
   int dy;

   always_comb begin
      dx = int'({1'b0, dst[ADDR_SIZE-1:HW]});
      dy = int'({1'b0, dst[HW-1:0]});
   end

   always_comb begin
      port = PORT_IDX_W'(PORT_LOCAL);
      if (dx > X_COORD)
         port = PORT_IDX_W'(PORT_E);
      else if (dx < X_COORD)
         port = PORT_IDX_W'(PORT_W);
      else if (dy > Y_COORD)
         port = PORT_IDX_W'(PORT_S);
      else if (dy < Y_COORD)
         port = PORT_IDX_W'(PORT_N);
   end

endmodule

// File: rtl/transmitter.sv
// Router output stage: pops the local FIFO, XY-routes each valid flit and holds
// it on one output port under a four-phase valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for a FIFO head; invalid heads are popped and dropped
// SEND    | flit driven on port_q, waiting for r_ready_in[port_q]=1
// RELEASE | flit accepted, waiting for r_ready_in[port_q]=0
module transmitter
   import noc_pkg::*;
#(
   parameter int DATA_SIZE  = 4,
   parameter int ADDR_SIZE  = 2,
   parameter int PORTS_NUM  = 4,
   parameter int X_COORD    = 0,
   parameter int Y_COORD    = 0,
   localparam int FW        = flit_w(DATA_SIZE, ADDR_SIZE),
   localparam int NP        = PORTS_NUM + 1
) (
   input  logic               clk,
   input  logic               a_rst,
   input  logic               is_empty,
   input  logic [FW-1:0]      data_i,
   output logic               rd_req,
   input  logic [NP-1:0]      r_ready_in,
   output logic [NP-1:0]      wr_ready_out,
   output logic [FW*NP-1:0]   data_o
);

   localparam int VB = valid_bit(DATA_SIZE, ADDR_SIZE);
   localparam int AL = addr_lsb(DATA_SIZE);
   localparam int OW = FW * NP;

   tx_state_e               state, state_d;
   logic [FW-1:0]           hold_q, hold_d;
   logic [PORT_IDX_W-1:0]   port_q, port_d, route_port;
   logic                    rd_req_d;
   logic [NP-1:0]           wr_d;
   logic [OW-1:0]           data_d;
   logic                    ack;
   logic                    can_pop;
   logic                    take;

   xy_route #(
      .ADDR_SIZE (ADDR_SIZE),
      .X_COORD   (X_COORD),
      .Y_COORD   (Y_COORD)
   ) u_route (
      .dst  (data_i[VB-1:AL]),
      .port (route_port)
   );

   assign ack = r_ready_in[port_q];
   // The FIFO pops on the edge after rd_req, so its head is stale while rd_req is high.
   assign can_pop = !is_empty && !rd_req;

   always_comb begin
      state_d  = state;
      hold_d   = hold_q;
      port_d   = port_q;
      rd_req_d = 1'b0;
      wr_d     = wr_ready_out;
      data_d   = data_o;
      take     = 1'b0;

      case (state)
         IDLE: take = can_pop;
         SEND: begin
            wr_d   = NP'(1) << port_q;
            data_d = OW'(hold_q) << (FW * port_q);
            if (ack) begin
               wr_d    = '0;
               data_d  = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!ack) begin
               if (can_pop)
                  take = 1'b1;
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         rd_req_d = 1'b1;
         if (data_i[VB]) begin
            hold_d  = data_i;
            port_d  = route_port;
            wr_d    = NP'(1) << route_port;
            data_d  = OW'(data_i) << (FW * route_port);
            state_d = SEND;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         state        <= IDLE;
         hold_q       <= '0;
         port_q       <= '0;
         rd_req       <= 1'b0;
         wr_ready_out <= '0;
         data_o       <= '0;
      end else begin
         state        <= state_d;
         hold_q       <= hold_d;
         port_q       <= port_d;
         rd_req       <= rd_req_d;
         wr_ready_out <= wr_d;
         data_o       <= data_d;
      end
   end

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: a FIFO model feeds flits, expected sends are
// queued at push time and matched by a monitor when each send starts.
module tb_transmitter;

   localparam int DS = 4;
   localparam int AS = 2;
   localparam int PN = 4;
   localparam int XC = 0;
   localparam int YC = 0;
   localparam int FW = DS + AS + 1;
   localparam int NP = PN + 1;
   localparam int OW = FW * NP;

   logic          clk = 1'b0;
   logic          a_rst;
   logic          is_empty;
   logic [FW-1:0] data_i;
   logic          rd_req;
   logic [NP-1:0] r_ready_in;
   logic [NP-1:0] wr_ready_out;
   logic [OW-1:0] data_o;

   always #5 clk = ~clk;

   transmitter #(
      .DATA_SIZE (DS),
      .ADDR_SIZE (AS),
      .PORTS_NUM (PN),
      .X_COORD   (XC),
      .Y_COORD   (YC)
   ) dut (
      .clk          (clk),
      .a_rst        (a_rst),
      .is_empty     (is_empty),
      .data_i       (data_i),
      .rd_req       (rd_req),
      .r_ready_in   (r_ready_in),
      .wr_ready_out (wr_ready_out),
      .data_o       (data_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference routing taken straight from the XY rule on coordinates.
   function automatic int ref_port(input logic [FW-1:0] f);
      int dx, dy;
      dx = int'(f[5]);
      dy = int'(f[4]);
      if (dx > XC) return 1;
      if (dx < XC) return 3;
      if (dy > YC) return 2;
      if (dy < YC) return 0;
      return 4;
   endfunction

   logic [FW-1:0] fifo_q[$];
   logic [9:0]    exp_q[$];
   int            pushes = 0;
   int            pops   = 0;
   bit            pop_pend = 1'b0;

   task automatic refresh();
      is_empty = (fifo_q.size() == 0);
      data_i   = (fifo_q.size() != 0) ? fifo_q[0] : FW'($urandom);
   endtask

   task automatic push_flit(input logic [FW-1:0] f);
      fifo_q.push_back(f);
      pushes++;
      if (f[FW-1])
         exp_q.push_back({3'(ref_port(f)), f});
      refresh();
   endtask

   // FIFO model: a pop requested during a cycle takes effect just after the next edge.
   always @(negedge clk) pop_pend = (rd_req === 1'b1);

   always @(posedge clk) begin
      if (pop_pend) begin
         #1;
         pop_pend = 1'b0;
         check("pop_nonempty", 64'(fifo_q.size() != 0), 64'(1));
         if (fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pops++;
         end
         refresh();
      end
   end

   logic [NP-1:0] prev_wr = '0;
   logic [OW-1:0] prev_do = '0;
   logic          prev_rd = 1'b0;
   logic [9:0]    e;

   always @(negedge clk) begin
      if (a_rst === 1'b1) begin
         check("onehot", 64'($countones(wr_ready_out) <= 1), 64'(1));
         check("rd_single_pulse", 64'(prev_rd && rd_req), 64'(0));
         if (wr_ready_out == '0) begin
            check("idle_data_zero", 64'(data_o), 64'(0));
         end else if (prev_wr == '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_send", 64'(wr_ready_out), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("send_port", 64'(wr_ready_out), 64'(NP'(1) << e[9:7]));
               check("send_data", 64'(data_o), 64'(OW'(e[6:0]) << (FW * e[9:7])));
            end
         end else begin
            check("hold_port", 64'(wr_ready_out), 64'(prev_wr));
            check("hold_data", 64'(data_o), 64'(prev_do));
         end
      end
      prev_wr = wr_ready_out;
      prev_do = data_o;
      prev_rd = rd_req;
   end

   function automatic int sel_port(input logic [NP-1:0] w);
      int p;
      p = 0;
      for (int i = 0; i < NP; i++)
         if (w[i]) p = i;
      return p;
   endfunction

   int p0;
   int ph, ap, dly, cyc;
   logic [FW-1:0] f;

   initial begin
      a_rst      = 1'b0;
      r_ready_in = '0;
      refresh();
      #2;
      check("rst_rd_req", 64'(rd_req), 64'(0));
      check("rst_wr_ready", 64'(wr_ready_out), 64'(0));
      check("rst_data_o", 64'(data_o), 64'(0));
      @(negedge clk);
      a_rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_quiet", 64'({rd_req, wr_ready_out, data_o}), 64'(0));
      end

      // East route
      push_flit(7'b1101010);
      @(negedge clk);
      check("east_rd_req", 64'(rd_req), 64'(1));
      check("east_wr", 64'(wr_ready_out), 64'(5'b00010));
      check("east_slice", 64'(data_o[13:7]), 64'(7'b1101010));
      r_ready_in[1] = 1'b1;
      @(negedge clk);
      check("east_ack_clears", 64'(wr_ready_out), 64'(0));
      r_ready_in[1] = 1'b0;
      @(negedge clk);

      // Local route; acks on the other ports must be ignored
      push_flit(7'b1000101);
      @(negedge clk);
      check("local_wr", 64'(wr_ready_out), 64'(5'b10000));
      check("local_slice", 64'(data_o[34:28]), 64'(7'b1000101));
      for (int i = 0; i < 4; i++) begin
         r_ready_in = NP'(1) << i;
         @(negedge clk);
         check("local_ignore_ack", 64'(wr_ready_out), 64'(5'b10000));
      end
      r_ready_in = 5'b10000;
      @(negedge clk);
      check("local_ack_clears", 64'(wr_ready_out), 64'(0));
      r_ready_in = '0;
      @(negedge clk);

      // Invalid flit drop
      p0 = pops;
      push_flit(7'b0111111);
      @(negedge clk);
      check("drop_rd_req", 64'(rd_req), 64'(1));
      check("drop_wr", 64'(wr_ready_out), 64'(0));
      @(negedge clk);
      check("drop_rd_req_low", 64'(rd_req), 64'(0));
      @(negedge clk);
      check("drop_pops", 64'(pops - p0), 64'(1));
      check("drop_wr_idle", 64'(wr_ready_out), 64'(0));

      // Back-to-back: south then east, south ack held for 3 cycles
      p0 = pops;
      push_flit(7'b1010011);
      push_flit(7'b1101010);
      @(negedge clk);
      check("b2b_first_wr", 64'(wr_ready_out), 64'(5'b00100));
      check("b2b_first_rd", 64'(rd_req), 64'(1));
      r_ready_in[2] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("b2b_wait_wr", 64'(wr_ready_out), 64'(0));
         check("b2b_wait_rd", 64'(rd_req), 64'(0));
      end
      r_ready_in[2] = 1'b0;
      @(negedge clk);
      check("b2b_second_wr", 64'(wr_ready_out), 64'(5'b00010));
      check("b2b_second_rd", 64'(rd_req), 64'(1));
      r_ready_in[1] = 1'b1;
      @(negedge clk);
      r_ready_in[1] = 1'b0;
      @(negedge clk);
      check("b2b_pops", 64'(pops - p0), 64'(2));

      // Reset while sending; the next head must be popped afresh
      push_flit(7'b1101010);
      @(negedge clk);
      check("rst_send_wr", 64'(wr_ready_out), 64'(5'b00010));
      push_flit(7'b1010011);
      @(negedge clk);
      a_rst = 1'b0;
      #1;
      check("rst_async_wr", 64'(wr_ready_out), 64'(0));
      check("rst_async_data", 64'(data_o), 64'(0));
      @(negedge clk);
      a_rst = 1'b1;
      @(negedge clk);
      check("rst_reread_rd", 64'(rd_req), 64'(1));
      check("rst_reread_wr", 64'(wr_ready_out), 64'(5'b00100));
      r_ready_in[2] = 1'b1;
      @(negedge clk);
      r_ready_in[2] = 1'b0;
      @(negedge clk);

      // Randomized traffic with a randomly delayed downstream responder
      ph  = 0;
      ap  = 0;
      dly = 0;
      cyc = 0;
      p0  = pushes;
      while (cyc < 20000) begin
         if ((pushes - p0) < 200 && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               f = FW'($urandom);
               f[FW-1] = ($urandom_range(0, 4) != 0);
               push_flit(f);
            end
         end
         if (ph == 0 && wr_ready_out != '0) begin
            ap  = sel_port(wr_ready_out);
            dly = $urandom_range(0, 3);
            ph  = 1;
         end
         if (ph == 1) begin
            if (dly == 0) begin
               r_ready_in[ap] = 1'b1;
               ph = 2;
            end else begin
               dly--;
            end
         end else if (ph == 2) begin
            if (wr_ready_out == '0) begin
               dly = $urandom_range(0, 2);
               ph  = 3;
            end
         end
         if (ph == 3) begin
            if (dly == 0) begin
               r_ready_in[ap] = 1'b0;
               ph = 0;
            end else begin
               dly--;
            end
         end
         @(negedge clk);
         cyc++;
         if ((pushes - p0) >= 200 && fifo_q.size() == 0 && ph == 0 &&
             wr_ready_out == '0 && rd_req == 1'b0)
            break;
      end
      check("random_drained_cycles", 64'(cyc < 20000), 64'(1));
      check("random_scoreboard_empty", 64'(exp_q.size()), 64'(0));
      check("random_fifo_empty", 64'(fifo_q.size()), 64'(0));
      check("total_pops", 64'(pops), 64'(pushes));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
